// File: rtl/sequential_encoder_pkg.sv
// rtl/sequential_encoder_pkg.sv - shared types for the sequential multi-hot to index encoder
package sequential_encoder_pkg;

  // Two-state controller: waiting for a word, or draining its set bits
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/sequential_encoder_one_hot_encoder.sv
// rtl/sequential_encoder_one_hot_encoder.sv - lowest-set-bit isolate and binary encode (zero input gives 0)
module one_hot_encoder #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0]         word,
  output logic [$clog2(WORD_WIDTH)-1:0] index
);

  localparam int INDEX_WIDTH = $clog2(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] lowest;

  // Two's complement trick keeps only the lowest set bit
  assign lowest = word & (~word + WORD_WIDTH'(1));

  // OR together the positions of the (at most one) set bit
  always_comb begin
    index = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (lowest[i]) begin
        index = index | INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/sequential_encoder.sv
// rtl/sequential_encoder.sv - serialise a multi-hot word into indices, lowest first (optional SEQUENTIAL_ENCODER_COUNT_EN)
module sequential_encoder
  import sequential_encoder_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORD_WIDTH-1:0]           in_word,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(WORD_WIDTH)-1:0]   out_index,
`ifdef SEQUENTIAL_ENCODER_COUNT_EN
  output logic [$clog2(WORD_WIDTH):0]     out_remaining,
`endif
  output logic                            out_last
);

  localparam int INDEX_WIDTH = $clog2(WORD_WIDTH);

  state_t                state;
  logic [WORD_WIDTH-1:0] pending;
  logic [WORD_WIDTH-1:0] pending_cleared;
  logic                  single_bit;
  logic                  out_fire;
  logic [INDEX_WIDTH-1:0] lowest_index;

  one_hot_encoder #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_one_hot_encoder (
    .word  (pending),
    .index (lowest_index)
  );

  // pending with its lowest set bit removed; exactly one bit set when this is zero
  assign pending_cleared = pending & (pending - WORD_WIDTH'(1));
  assign single_bit      = (pending != '0) && (pending_cleared == '0);

  // Outputs depend only on registered state, never on in_* directly
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_index = (state == EMIT) ? lowest_index : '0;
  assign out_last  = (state == EMIT) && single_bit;
  assign out_fire  = out_valid && out_ready;

  // Controller and pending register: load on accept, peel one bit per output transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && (in_word != '0)) begin
            pending <= in_word;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (out_fire) begin
            pending <= pending_cleared;
            if (single_bit) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

`ifdef SEQUENTIAL_ENCODER_COUNT_EN
  // Popcount of pending; pending is zero in IDLE so this reads 0 there
  always_comb begin
    out_remaining = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      out_remaining = out_remaining + (INDEX_WIDTH + 1)'(pending[i]);
    end
  end
`endif

endmodule

// File: tb/tb_sequential_encoder.sv
// tb/tb_sequential_encoder.sv - randomized self-checking bench against a queue-based index model
module tb_sequential_encoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_word = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   out_index;
  logic         out_last;
`ifdef SEQUENTIAL_ENCODER_COUNT_EN
  logic [3:0]   out_remaining;
`endif

  int checks = 0;
  int errors = 0;
  int q[$];

  always #5 clk = ~clk;

  sequential_encoder #(.WORD_WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_word       (in_word),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
`ifdef SEQUENTIAL_ENCODER_COUNT_EN
    .out_remaining (out_remaining),
`endif
    .out_last      (out_last)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected outputs from the model: the queue holds the indices still to be emitted
  task automatic compare_outputs();
    int n;
    n = q.size();
    check("in_ready", 32'(in_ready), 32'(n == 0));
    check("out_valid", 32'(out_valid), 32'(n != 0));
    check("out_index", 32'(out_index), (n != 0) ? 32'(q[0]) : 32'd0);
    check("out_last", 32'(out_last), 32'(n == 1));
`ifdef SEQUENTIAL_ENCODER_COUNT_EN
    check("out_remaining", 32'(out_remaining), 32'(n));
`endif
  endtask

  task automatic step(input logic v, input logic [W-1:0] w, input logic r);
    @(negedge clk);
    compare_outputs();
    in_valid  = v;
    in_word   = w;
    out_ready = r;
    if (q.size() == 0) begin
      if (v) begin
        for (int i = 0; i < W; i++) begin
          if (w[i]) q.push_back(i);
        end
      end
    end else if (r) begin
      void'(q.pop_front());
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;

    // zero word consumed without emission
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // simple drain
    step(1'b1, 8'hA4, 1'b1);
    drain();

    // backpressure
    step(1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    drain();

    // all bits, MSB only, count pattern
    step(1'b1, 8'hFF, 1'b1);
    drain();
    step(1'b1, 8'h80, 1'b1);
    drain();
    step(1'b1, 8'h69, 1'b1);
    drain();

    // reset mid-EMIT
    step(1'b1, 8'hF0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h01, 1'b1);
    drain();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      if ($urandom_range(0, 7) == 0) w = '0;
      if ($urandom_range(0, 7) == 0) w = W'(1) << $urandom_range(0, W - 1);
      step(1'(($urandom_range(0, 3) != 0)), w, 1'(($urandom_range(0, 9) < 7)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
